tmr_resync_ctrl: RTL and testbench

Controller that supervises three redundant replicas of a DATA_WIDTH state word. It votes the replica words bit-wise and identifies the faulty replica on a mismatch. It then sequences a stall/resynchronisation handshake that reloads all replicas with the voted word. It sits between the triplicated core copies and the per-bit majority voters, and reports error statistics to the safety/status register block.

---
 rtl/tmr_resync_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_tmr_resync_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_resync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tmr_resync_ctrl
// Purpose  : Supervises three redundant replicas of a state word. It votes
//            the words bit-wise and flags the faulty replica(s) on a mismatch.
//            It then runs a stall / resynchronisation handshake that reloads
//            every replica with the voted word.
// Ports    : clk_i, rst_ni (async, active-low)
//            data_a_i/data_b_i/data_c_i, valid_i  - replica words to compare
//            voted_o                               - combinational majority
//            stall_req_o / stall_ack_i             - freeze handshake
//            resync_o / resync_data_o              - reload strobe and word
//            mismatch_o, faulty_o, fatal_o, busy_o - status
//            clr_cnt_i, err_cnt_{a,b,c}_o          - per-replica error counts
// Options  : TMR_RESYNC_ERR_CNT_EN - builds the saturating error counters;
//            when undefined the counts read 0 and clr_cnt_i is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_resync_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int RESYNC_CYCLES = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] data_a_i,
   input  logic [DATA_WIDTH-1:0] data_b_i,
   input  logic [DATA_WIDTH-1:0] data_c_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] voted_o,
   output logic                  stall_req_o,
   input  logic                  stall_ack_i,
   output logic                  resync_o,
   output logic [DATA_WIDTH-1:0] resync_data_o,
   output logic                  mismatch_o,
   output logic [2:0]            faulty_o,
   output logic                  fatal_o,
   output logic                  busy_o,
   input  logic                  clr_cnt_i,
   output logic [CNT_WIDTH-1:0]  err_cnt_a_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_b_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_c_o
);

   localparam int                 c_TMR_W    = $clog2(RESYNC_CYCLES + 1);
   localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(RESYNC_CYCLES);
   localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STALL  = 2'd1,
      S_RESYNC = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_TMR_W-1:0]  r_tmr, w_tmr_nxt;
   logic [DATA_WIDTH-1:0] r_resync_data;
   logic [2:0]          r_faulty;
   logic                r_mismatch;
   logic                r_fatal;

   logic [2:0]          w_flags;
   logic                w_multi;
   logic                w_detect;

   // ---------------------------------------------------------------------
   // Voting and fault identification
   // ---------------------------------------------------------------------
   assign voted_o = (data_a_i & data_b_i) | (data_a_i & data_c_i) | (data_b_i & data_c_i);

   // A replica is faulty when some bit of it disagrees with both others.
   assign w_flags[0] = |((data_a_i ^ data_b_i) & (data_a_i ^ data_c_i));
   assign w_flags[1] = |((data_b_i ^ data_a_i) & (data_b_i ^ data_c_i));
   assign w_flags[2] = |((data_c_i ^ data_a_i) & (data_c_i ^ data_b_i));

   // Two or more flagged replicas cannot be corrected reliably.
   assign w_multi  = (w_flags[0] & w_flags[1]) | (w_flags[0] & w_flags[2]) |
                     (w_flags[1] & w_flags[2]);

   // Comparisons are only acted on while idle; anything seen mid-handshake is dropped.
   assign w_detect = (r_state == S_IDLE) && valid_i && (|w_flags);

   // ---------------------------------------------------------------------
   // Handshake FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      stall_req_o = 1'b0;
      resync_o    = 1'b0;
      busy_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_detect) w_state_nxt = S_STALL;
         end
         S_STALL: begin
            stall_req_o = 1'b1;
            busy_o      = 1'b1;
            if (stall_ack_i) begin
               w_state_nxt = S_RESYNC;
               w_tmr_nxt   = c_TMR_LOAD;
            end
         end
         S_RESYNC: begin
            stall_req_o = 1'b1;
            resync_o    = 1'b1;
            busy_o      = 1'b1;
            // Timer holds the number of resync cycles still to run, this one included.
            if (r_tmr <= c_TMR_LAST) begin
               w_state_nxt = S_IDLE;
               w_tmr_nxt   = '0;
            end else begin
               w_tmr_nxt   = r_tmr - c_TMR_LAST;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tmr_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Detection capture and status
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_resync_data <= '0;
         r_faulty      <= '0;
         r_mismatch    <= 1'b0;
         r_fatal       <= 1'b0;
      end else begin
         r_mismatch <= w_detect;
         if (w_detect) begin
            r_resync_data <= voted_o;
            r_faulty      <= w_flags;
            if (w_multi) r_fatal <= 1'b1;
         end
      end
   end

   assign resync_data_o = r_resync_data;
   assign faulty_o      = r_faulty;
   assign mismatch_o    = r_mismatch;
   assign fatal_o       = r_fatal;

   // ---------------------------------------------------------------------
   // Per-replica error counters
   // ---------------------------------------------------------------------
`ifdef TMR_RESYNC_ERR_CNT_EN
   for (genvar gi = 0; gi < 3; gi++) begin : g_err_cnt
      logic [CNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_cnt <= '0;
         end else if (clr_cnt_i) begin
            r_cnt <= '0;
         end else if (w_detect && w_flags[gi] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
      end
   end
   assign err_cnt_a_o = g_err_cnt[0].r_cnt;
   assign err_cnt_b_o = g_err_cnt[1].r_cnt;
   assign err_cnt_c_o = g_err_cnt[2].r_cnt;
`else
   logic w_unused_clr;
   assign w_unused_clr = clr_cnt_i;
   assign err_cnt_a_o  = '0;
   assign err_cnt_b_o  = '0;
   assign err_cnt_c_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmr_resync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_resync_ctrl
// Purpose  : Directed self-checking bench for tmr_resync_ctrl. A vector table
//            covers the combinational vote; hand-written sequences cover the
//            handshake timing, multi-fault, counters and asynchronous reset.
//            Expected counter values follow TMR_RESYNC_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_resync_ctrl;

   localparam int DW = 32;
   localparam int RC = 4;
   localparam int CW = 2;

`ifdef TMR_RESYNC_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] a, b, c;
   logic          valid, ack, clr;
   logic [DW-1:0] voted, rdata;
   logic          stall_req, resync, mismatch, fatal, busy;
   logic [2:0]    faulty;
   logic [CW-1:0] cnt_a, cnt_b, cnt_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tmr_resync_ctrl #(
      .DATA_WIDTH   (DW),
      .RESYNC_CYCLES(RC),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .data_a_i     (a),
      .data_b_i     (b),
      .data_c_i     (c),
      .valid_i      (valid),
      .voted_o      (voted),
      .stall_req_o  (stall_req),
      .stall_ack_i  (ack),
      .resync_o     (resync),
      .resync_data_o(rdata),
      .mismatch_o   (mismatch),
      .faulty_o     (faulty),
      .fatal_o      (fatal),
      .busy_o       (busy),
      .clr_cnt_i    (clr),
      .err_cnt_a_o  (cnt_a),
      .err_cnt_b_o  (cnt_b),
      .err_cnt_c_o  (cnt_c)
   );

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] c;
      logic [DW-1:0] voted;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [CW-1:0] ec(input int v);
      return CNT_EN ? CW'(v) : '0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"},  stall_req, 0);
      check({tag, "_resync"}, resync,    0);
      check({tag, "_rdata"},  rdata,     0);
      check({tag, "_mism"},   mismatch,  0);
      check({tag, "_faulty"}, faulty,    0);
      check({tag, "_fatal"},  fatal,     0);
      check({tag, "_busy"},   busy,      0);
      check({tag, "_cnt_a"},  cnt_a,     0);
      check({tag, "_cnt_b"},  cnt_b,     0);
      check({tag, "_cnt_c"},  cnt_c,     0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && busy; i++) tick();
      check("idle_reached", busy, 0);
   endtask

   // Presents one faulty word set with immediate ack and runs it to IDLE.
   task automatic run_fault(input logic [DW-1:0] fa, input logic [DW-1:0] fb,
                            input logic [DW-1:0] fc, input logic [2:0] exp_f);
      a = fa; b = fb; c = fc; valid = 1'b1; ack = 1'b1;
      tick();
      check("rf_mismatch", mismatch, 1);
      check("rf_faulty",   faulty,   exp_f);
      valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
      vecs[2] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF00_FF00};
      vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
      vecs[4] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_FFFF, 32'h0000_FFFF};
      vecs[5] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_0000};

      rst_n = 1'b0; a = '0; b = '0; c = '0; valid = 1'b0; ack = 1'b0; clr = 1'b0;
      tick(); tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Combinational vote table; valid low so no handshake starts.
      for (int i = 0; i < 6; i++) begin
         a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
         #1;
         check($sformatf("vote_%0d", i), voted, vecs[i].voted);
      end
      tick();
      check("vote_no_busy", busy, 0);

      // Clean operation.
      a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; c = 32'hDEAD_BEEF; valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("clean_voted", voted, 32'hDEAD_BEEF);
         check("clean_mism",  mismatch, 0);
         check("clean_busy",  busy, 0);
         check("clean_stall", stall_req, 0);
      end

      // Single fault on a with fast ack.
      a = 32'h1; b = 32'h0; c = 32'h0; valid = 1'b1; ack = 1'b1;
      tick();
      check("fast_mism",   mismatch, 1);
      check("fast_stall",  stall_req, 1);
      check("fast_busy",   busy, 1);
      check("fast_faulty", faulty, 3'b001);
      check("fast_rdata",  rdata, 0);
      check("fast_resync_early", resync, 0);
      valid = 1'b0; a = '0;
      for (int i = 0; i < RC; i++) begin
         tick();
         check("fast_resync", resync, 1);
         check("fast_mism_once", mismatch, 0);
      end
      tick();
      check("fast_resync_end", resync, 0);
      check("fast_stall_end",  stall_req, 0);
      check("fast_busy_end",   busy, 0);
      check("fast_cnt_a",      cnt_a, ec(1));

      // Delayed ack with b faulty; a c fault during STALL is ignored.
      ack = 1'b0;
      a = 32'h10; b = 32'h11; c = 32'h10; valid = 1'b1;
      tick();
      check("dly_faulty", faulty, 3'b010);
      check("dly_rdata",  rdata, 32'h10);
      check("dly_stall",  stall_req, 1);
      a = 32'h5; b = 32'h5; c = 32'h7;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("dly_no_resync", resync, 0);
         check("dly_no_mism",   mismatch, 0);
      end
      ack = 1'b1; valid = 1'b0;
      tick();
      check("dly_resync_start", resync, 1);
      ack = 1'b0;
      for (int i = 1; i < RC; i++) begin
         tick();
         check("dly_resync", resync, 1);
      end
      tick();
      check("dly_resync_end", resync, 0);
      check("dly_faulty_hold", faulty, 3'b010);
      check("dly_cnt_b", cnt_b, ec(1));
      check("dly_cnt_c", cnt_c, ec(0));

      // Multi-replica fault.
      a = 32'h1; b = 32'h2; c = 32'h0; valid = 1'b1; ack = 1'b1;
      tick();
      check("multi_faulty", faulty, 3'b011);
      check("multi_fatal",  fatal, 1);
      check("multi_rdata",  rdata, 0);
      valid = 1'b0;
      wait_idle();
      check("multi_fatal_sticky", fatal, 1);
      check("multi_cnt_a", cnt_a, ec(2));
      check("multi_cnt_b", cnt_b, ec(2));

      // Saturation on c, then clear colliding with a detection.
      for (int i = 0; i < 5; i++) run_fault(32'h0, 32'h0, 32'hF, 3'b100);
      check("sat_cnt_c", cnt_c, ec(3));
      clr = 1'b1; a = '0; b = '0; c = 32'hF; valid = 1'b1; ack = 1'b1;
      tick();
      clr = 1'b0; valid = 1'b0;
      check("clr_mism",  mismatch, 1);
      check("clr_cnt_a", cnt_a, 0);
      check("clr_cnt_b", cnt_b, 0);
      check("clr_cnt_c", cnt_c, 0);
      wait_idle();

      // Asynchronous reset during the second resync cycle.
      a = '0; b = '0; c = 32'h3; valid = 1'b1; ack = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      check("rst_resync1", resync, 1);
      tick();
      check("rst_resync2", resync, 1);
      check("rst_pre_fatal", fatal, 1);
      check("rst_pre_cnt_c", cnt_c, ec(1));
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_busy",   busy, 0);
      check("post_rst_resync", resync, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
